// File: rtl/user_io_ms.sv
// Single-clock SPI slave between the IO controller and the core: keyboard in/out,
// joysticks, SD sector/config transfer, image mount and RTC, all oversampled in clk_sys.
module user_io_ms #(
  parameter logic [7:0] CORE_TYPE  = 8'ha6,
  parameter int         NUM_JOY    = 2,
  parameter int         JOY_BYTES  = 4,
  parameter int         NUM_DRIVES = 2,
  parameter int         KBD_DEPTH  = 8
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            SPI_CLK,
  input  logic                            SPI_SS_IO,
  input  logic                            SPI_MOSI,
  output logic                            SPI_MISO,
  output logic [NUM_JOY*JOY_BYTES*8-1:0]  joystick,
  output logic [1:0]                      buttons,
  output logic [1:0]                      switches,
  output logic                            scandoubler_disable,
  output logic                            ypbpr,
  output logic                            no_csync,
  output logic [63:0]                     rtc,
  input  logic [7:0]                      kbd_out_data,
  input  logic                            kbd_out_strobe,
  output logic                            kbd_out_full,
  output logic [7:0]                      kbd_in_data,
  output logic                            kbd_in_strobe,
  input  logic [32*NUM_DRIVES-1:0]        sd_lba,
  input  logic [NUM_DRIVES-1:0]           sd_rd,
  input  logic [NUM_DRIVES-1:0]           sd_wr,
  input  logic                            sd_conf,
  input  logic                            sd_sdhc,
  output logic [NUM_DRIVES-1:0]           sd_ack,
  output logic                            sd_ack_conf,
  output logic [7:0]                      sd_dout,
  output logic                            sd_dout_strobe,
  input  logic [7:0]                      sd_din,
  output logic [8:0]                      sd_buff_addr,
  output logic [NUM_DRIVES-1:0]           img_mounted,
  output logic [31:0]                     img_size
);

  localparam int         JW       = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1;
  localparam int         DW       = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam int         AW       = $clog2(KBD_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(KBD_DEPTH);
  localparam logic [7:0] JOY_LAST = 8'(8'h60 + NUM_JOY - 1);

  localparam logic [7:0] CMD_BUT_SW     = 8'h01;
  localparam logic [7:0] CMD_KBD_OUT    = 8'h04;
  localparam logic [7:0] CMD_KBD_IN     = 8'h05;
  localparam logic [7:0] CMD_SD_STAT    = 8'h16;
  localparam logic [7:0] CMD_SD_RD_DATA = 8'h17;
  localparam logic [7:0] CMD_SD_WR_DATA = 8'h18;
  localparam logic [7:0] CMD_SD_CONF    = 8'h19;
  localparam logic [7:0] CMD_MOUNT      = 8'h1c;
  localparam logic [7:0] CMD_IMG_SIZE   = 8'h1d;
  localparam logic [7:0] CMD_RTC        = 8'h22;

  // synchronisers; r_sck_s[2] is the previous synced SCK for edge detection
  logic [2:0] r_sck_s;
  logic [1:0] r_ss_s;
  logic [1:0] r_mosi_s;
  logic       w_rise, w_fall, w_ss, w_mosi;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sck_s  <= '0;
      r_ss_s   <= '0;
      r_mosi_s <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[1:0], SPI_CLK};
      r_ss_s   <= {r_ss_s[0], SPI_SS_IO};
      r_mosi_s <= {r_mosi_s[0], SPI_MOSI};
    end
  end

  assign w_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_fall = ~r_sck_s[1] & r_sck_s[2];
  assign w_ss   = r_ss_s[1];
  assign w_mosi = r_mosi_s[1];

  logic                         r_armed;
  logic [2:0]                   r_bit;
  logic [6:0]                   r_sr;
  logic [9:0]                   r_byte_cnt;
  logic                         r_bstb;
  logic [7:0]                   r_bdata;
  logic [9:0]                   r_bidx;
  logic [7:0]                   r_cmd;
  logic [7:0]                   r_tx;
  logic                         r_miso;
  logic [DW-1:0]                r_drive;
  logic [31:0]                  r_lba;
  logic [6:0]                   r_but_sw;
  logic [NUM_JOY-1:0][JOY_BYTES*8-1:0] r_joy;
  logic [63:0]                  r_rtc;
  logic [31:0]                  r_img_size;
  logic [NUM_DRIVES-1:0]        r_img_mounted;
  logic [7:0]                   r_kbd_in_data;
  logic                         r_kbd_in_strobe;
  logic [NUM_DRIVES-1:0]        r_sd_ack;
  logic                         r_ack_conf;
  logic [7:0]                   r_sd_dout;
  logic                         r_sd_dout_strobe;
  logic [8:0]                   r_addr;

  // kbd-out FIFO
  logic [7:0]    r_mem [KBD_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_full, w_avail, w_pop, w_ovf_clr, w_push_ok;

  logic [DW-1:0] w_drive;
  logic [DW-1:0] w_mnt_idx;
  logic [JW-1:0] w_joy_n;
  logic          w_joy_hit;
  logic [7:0]    w_tx;

  assign w_full    = (r_cnt == FULL_CNT);
  assign w_avail   = (r_cnt != '0);
  assign w_pop     = r_bstb && (r_cmd == CMD_KBD_OUT) && (r_bidx == 10'd2) && w_avail;
  assign w_ovf_clr = r_bstb && (r_cmd == CMD_KBD_OUT) && (r_bidx == 10'd1);
  assign w_push_ok = kbd_out_strobe && (!w_full || w_pop);
  assign w_joy_hit = (r_cmd >= 8'h60) && (r_cmd <= JOY_LAST);
  assign w_joy_n   = JW'(r_cmd - 8'h60);
  assign w_mnt_idx = DW'(32'(r_bdata) % NUM_DRIVES);

  // lowest-numbered drive with a pending request wins
  always_comb begin
    w_drive = '0;
    for (int d = NUM_DRIVES - 1; d >= 0; d--)
      if (sd_rd[d] | sd_wr[d]) w_drive = DW'(d);
  end

  // byte to shift out for the byte that starts now (r_byte_cnt = its index)
  always_comb begin
    w_tx = 8'h00;
    if (r_byte_cnt == 10'd0) begin
      w_tx = CORE_TYPE;
    end else begin
      case (r_cmd)
        CMD_KBD_OUT: begin
          if (r_byte_cnt == 10'd1)      w_tx = {4'ha, 2'b00, r_ovf, w_avail};
          else if (r_byte_cnt == 10'd2) w_tx = r_mem[r_rd];
        end
        CMD_SD_STAT: begin
          case (r_byte_cnt)
            10'd1:   w_tx = {4'h6, sd_conf, sd_sdhc, sd_wr[w_drive], sd_rd[w_drive]};
            10'd2:   w_tx = 8'(r_drive);
            10'd3:   w_tx = r_lba[31:24];
            10'd4:   w_tx = r_lba[23:16];
            10'd5:   w_tx = r_lba[15:8];
            10'd6:   w_tx = r_lba[7:0];
            default: w_tx = 8'h00;
          endcase
        end
        CMD_SD_WR_DATA: w_tx = sd_din;
        default:        w_tx = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_armed          <= 1'b0;
      r_bit            <= '0;
      r_sr             <= '0;
      r_byte_cnt       <= '0;
      r_bstb           <= 1'b0;
      r_bdata          <= '0;
      r_bidx           <= '0;
      r_cmd            <= '0;
      r_tx             <= '0;
      r_miso           <= 1'b0;
      r_drive          <= '0;
      r_lba            <= '0;
      r_but_sw         <= '0;
      r_joy            <= '0;
      r_rtc            <= '0;
      r_img_size       <= '0;
      r_img_mounted    <= '0;
      r_kbd_in_data    <= '0;
      r_kbd_in_strobe  <= 1'b0;
      r_sd_ack         <= '0;
      r_ack_conf       <= 1'b0;
      r_sd_dout        <= '0;
      r_sd_dout_strobe <= 1'b0;
      r_addr           <= '0;
    end else begin
      r_bstb           <= 1'b0;
      r_kbd_in_strobe  <= 1'b0;
      r_sd_dout_strobe <= 1'b0;
      r_img_mounted    <= '0;

      if (r_bstb) begin
        if (r_bidx == 10'd0) begin
          r_cmd <= r_bdata;
          if (r_bdata == CMD_SD_RD_DATA || r_bdata == CMD_SD_WR_DATA)
            for (int d = 0; d < NUM_DRIVES; d++) r_sd_ack[d] <= (DW'(d) == r_drive);
          if (r_bdata == CMD_SD_WR_DATA) r_addr <= '0;
          if (r_bdata == CMD_SD_CONF)    r_ack_conf <= 1'b1;
        end else begin
          case (r_cmd)
            CMD_BUT_SW: if (r_bidx == 10'd1) r_but_sw <= r_bdata[6:0];
            CMD_KBD_IN: begin
              r_kbd_in_data   <= r_bdata;
              r_kbd_in_strobe <= 1'b1;
            end
            CMD_SD_RD_DATA, CMD_SD_CONF: begin
              r_sd_dout        <= r_bdata;
              r_sd_dout_strobe <= 1'b1;
            end
            CMD_SD_WR_DATA: if (r_addr != 9'd511) r_addr <= r_addr + 9'd1;
            CMD_MOUNT:      r_img_mounted[w_mnt_idx] <= 1'b1;
            CMD_IMG_SIZE:
              for (int b = 0; b < 4; b++)
                if (r_bidx == 10'(b + 1)) r_img_size[b*8 +: 8] <= r_bdata;
            CMD_RTC:
              for (int b = 0; b < 8; b++)
                if (r_bidx == 10'(b + 1)) r_rtc[b*8 +: 8] <= r_bdata;
            default:
              if (w_joy_hit)
                for (int b = 0; b < JOY_BYTES; b++)
                  if (r_bidx == 10'(b + 1)) r_joy[w_joy_n][b*8 +: 8] <= r_bdata;
          endcase
        end
      end

      // sector address advances the cycle after the core has seen the byte
      if (r_sd_dout_strobe && (r_cmd == CMD_SD_RD_DATA) && (r_addr != 9'd511))
        r_addr <= r_addr + 9'd1;

      if (w_ss) begin
        r_armed    <= 1'b1;
        r_bit      <= '0;
        r_byte_cnt <= '0;
        r_sd_ack   <= '0;
        r_ack_conf <= 1'b0;
        r_addr     <= '0;
        r_tx       <= CORE_TYPE;
        r_miso     <= CORE_TYPE[7];
      end else if (r_armed) begin
        if (w_rise) begin
          r_sr  <= {r_sr[5:0], w_mosi};
          r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            r_bstb  <= 1'b1;
            r_bdata <= {r_sr, w_mosi};
            r_bidx  <= r_byte_cnt;
            if (r_byte_cnt != 10'd1023) r_byte_cnt <= r_byte_cnt + 10'd1;
          end
        end
        if (w_fall) begin
          if (r_bit == 3'd0) begin
            r_tx   <= w_tx;
            r_miso <= w_tx[7];
            if (r_byte_cnt == 10'd1) begin
              r_drive <= w_drive;
              r_lba   <= sd_lba[32*w_drive +: 32];
            end
          end else begin
            r_miso <= r_tx[3'd7 - r_bit];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (kbd_out_strobe && !w_push_ok) r_ovf <= 1'b1;
      else if (w_ovf_clr)               r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push_ok) r_mem[r_wr] <= kbd_out_data;
  end

  assign SPI_MISO            = SPI_SS_IO ? 1'bz : r_miso;
  assign joystick            = r_joy;
  assign buttons             = r_but_sw[1:0];
  assign switches            = r_but_sw[3:2];
  assign scandoubler_disable = r_but_sw[4];
  assign ypbpr               = r_but_sw[5];
  assign no_csync            = r_but_sw[6];
  assign rtc                 = r_rtc;
  assign kbd_out_full        = w_full;
  assign kbd_in_data         = r_kbd_in_data;
  assign kbd_in_strobe       = r_kbd_in_strobe;
  assign sd_ack              = r_sd_ack;
  assign sd_ack_conf         = r_ack_conf;
  assign sd_dout             = r_sd_dout;
  assign sd_dout_strobe      = r_sd_dout_strobe;
  assign sd_buff_addr        = r_addr;
  assign img_mounted         = r_img_mounted;
  assign img_size            = r_img_size;

endmodule

// File: tb/tb_user_io_ms.sv
// Bench for user_io_ms: SPI host driver, MISO byte scoreboard and strobe monitors
// for sd_dout, kbd_in and img_mounted.
module tb_user_io_ms;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_ss, spi_mosi;
  wire         spi_miso;
  logic [63:0] joystick;
  logic [1:0]  buttons, switches;
  logic        scandoubler_disable, ypbpr, no_csync;
  logic [63:0] rtc;
  logic [7:0]  kbd_out_data;
  logic        kbd_out_strobe, kbd_out_full;
  logic [7:0]  kbd_in_data;
  logic        kbd_in_strobe;
  logic [63:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_conf, sd_sdhc;
  logic [1:0]  sd_ack;
  logic        sd_ack_conf;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic [7:0]  sd_din, din_d1;
  logic [8:0]  sd_buff_addr;
  logic [1:0]  img_mounted;
  logic [31:0] img_size;

  int n_checks = 0;
  int n_fail   = 0;
  int half     = 4;

  logic [7:0]  exp_q[$];       // expected MISO bytes
  logic [17:0] dout_q[$];      // {check_addr, addr, data}
  logic [7:0]  kbd_q[$];
  logic [1:0]  mnt_q[$];

  user_io_ms dut (
    .clk_sys(clk), .reset(reset),
    .SPI_CLK(spi_clk), .SPI_SS_IO(spi_ss), .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso),
    .joystick(joystick), .buttons(buttons), .switches(switches),
    .scandoubler_disable(scandoubler_disable), .ypbpr(ypbpr), .no_csync(no_csync),
    .rtc(rtc), .kbd_out_data(kbd_out_data), .kbd_out_strobe(kbd_out_strobe),
    .kbd_out_full(kbd_out_full), .kbd_in_data(kbd_in_data), .kbd_in_strobe(kbd_in_strobe),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_conf(sd_conf), .sd_sdhc(sd_sdhc),
    .sd_ack(sd_ack), .sd_ack_conf(sd_ack_conf), .sd_dout(sd_dout),
    .sd_dout_strobe(sd_dout_strobe), .sd_din(sd_din), .sd_buff_addr(sd_buff_addr),
    .img_mounted(img_mounted), .img_size(img_size)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // sector buffer model: data is a function of address, two clocks of latency
  always @(posedge clk) begin
    din_d1 <= sd_buff_addr[7:0] ^ 8'h3c;
    sd_din <= din_d1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // strobe monitors, sampled on the falling clk edge
  always @(negedge clk) begin
    if (!reset && sd_dout_strobe) begin
      if (dout_q.size() == 0) check("dout_unexpected", 64'(sd_dout_strobe), 64'd0);
      else begin
        logic [17:0] e;
        e = dout_q.pop_front();
        check("sd_dout", 64'(sd_dout), 64'(e[7:0]));
        if (e[17]) check("sd_buff_addr_strobe", 64'(sd_buff_addr), 64'(e[16:8]));
      end
    end
    if (!reset && kbd_in_strobe) begin
      if (kbd_q.size() == 0) check("kbd_in_unexpected", 64'(kbd_in_strobe), 64'd0);
      else check("kbd_in_data", 64'(kbd_in_data), 64'(kbd_q.pop_front()));
    end
    if (!reset && img_mounted != 2'b00) begin
      if (mnt_q.size() == 0) check("mount_unexpected", 64'(img_mounted), 64'd0);
      else check("img_mounted", 64'(img_mounted), 64'(mnt_q.pop_front()));
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    spi_ss = 1'b0;
    wait_clk(4);
  endtask

  task automatic frame_end();
    wait_clk(half);
    spi_ss = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      wait_clk(half);
      spi_clk = 1'b1;
      rx[i] = spi_miso;
      wait_clk(half);
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input bit chk, input string tag);
    logic [7:0] rx;
    if (chk) exp_q.push_back(exp);
    spi_bits(tx, 8, rx);
    if (chk) check(tag, 64'(rx), 64'(exp_q.pop_front()));
  endtask

  task automatic kbd_push(input logic [7:0] d);
    kbd_out_data   = d;
    kbd_out_strobe = 1'b1;
    wait_clk(1);
    kbd_out_strobe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx, d;
    logic [31:0] v32;
    logic [63:0] v64;
    reset = 1'b1; spi_clk = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;
    kbd_out_data = 8'h00; kbd_out_strobe = 1'b0;
    sd_lba = 64'h0; sd_rd = 2'b00; sd_wr = 2'b00; sd_conf = 1'b0; sd_sdhc = 1'b0;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(3);

    check("rst_joystick", joystick, 64'h0);
    check("rst_sd_ack", 64'(sd_ack), 64'h0);
    check("rst_kbd_full", 64'(kbd_out_full), 64'h0);
    check("rst_addr", 64'(sd_buff_addr), 64'h0);
    check("rst_img_size", 64'(img_size), 64'h0);
    check("rst_rtc", rtc, 64'h0);

    // core type, abandoned partial byte, unknown command
    frame_start(); xfer(8'h00, 8'ha6, 1, "core_type"); frame_end();
    frame_start(); spi_bits(8'hff, 4, rx); frame_end();
    frame_start(); xfer(8'h00, 8'ha6, 1, "core_type_after_partial");
    xfer(8'h12, 8'h00, 1, "unknown_cmd_miso"); frame_end();

    // buttons / switches
    frame_start(); xfer(8'h01, 8'ha6, 1, "b0"); xfer(8'h55, 8'h00, 0, ""); frame_end();
    check("but_sw", 64'({no_csync, ypbpr, scandoubler_disable, switches, buttons}), 64'h55);

    // joysticks: channel 1, channel 0, out-of-range channel 2 ignored
    frame_start(); xfer(8'h61, 8'ha6, 0, "");
    foreach (v32[i]) ;
    xfer(8'haa, 0, 0, ""); xfer(8'hbb, 0, 0, ""); xfer(8'hcc, 0, 0, ""); xfer(8'hdd, 0, 0, "");
    frame_end();
    check("joy_ch1", joystick, 64'hddccbbaa_00000000);
    v32 = $urandom();
    frame_start(); xfer(8'h60, 8'ha6, 0, "");
    for (int b = 0; b < 4; b++) xfer(v32[b*8 +: 8], 0, 0, "");
    frame_end();
    check("joy_ch0", joystick, {32'hddccbbaa, v32});
    frame_start(); xfer(8'h62, 8'ha6, 0, "");
    for (int b = 0; b < 4; b++) xfer(8'hee, 0, 0, "");
    frame_end();
    check("joy_ch2_ignored", joystick, {32'hddccbbaa, v32});

    // kbd-out FIFO: three bytes then empty
    kbd_push(8'h11); kbd_push(8'h22); kbd_push(8'h33);
    for (int k = 0; k < 3; k++) begin
      frame_start(); xfer(8'h04, 8'ha6, 1, "kbd_b0");
      xfer(8'h00, 8'ha1, 1, "kbd_status");
      xfer(8'h00, 8'h11 * 8'(k + 1), 1, "kbd_head");
      frame_end();
    end
    frame_start(); xfer(8'h04, 8'ha6, 0, ""); xfer(8'h00, 8'ha0, 1, "kbd_status_empty"); frame_end();

    // overflow: nine pushes into eight entries
    for (int k = 0; k < 9; k++) kbd_push(8'h40 + 8'(k));
    wait_clk(1);
    check("kbd_full", 64'(kbd_out_full), 64'h1);
    frame_start(); xfer(8'h04, 8'ha6, 0, "");
    xfer(8'h00, 8'ha3, 1, "kbd_status_ovf"); xfer(8'h00, 8'h40, 1, "kbd_head_ovf"); frame_end();
    check("kbd_not_full", 64'(kbd_out_full), 64'h0);
    frame_start(); xfer(8'h04, 8'ha6, 0, "");
    xfer(8'h00, 8'ha1, 1, "kbd_status_ovf_clr"); xfer(8'h00, 8'h41, 1, "kbd_head2"); frame_end();

    // kbd-in burst
    frame_start(); xfer(8'h05, 8'ha6, 0, "");
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom_range(0, 255));
      kbd_q.push_back(d);
      xfer(d, 0, 0, "");
    end
    frame_end();

    // SD status for drive 1
    sd_rd = 2'b10; sd_lba = {32'h12345678, 32'hdeadbeef};
    frame_start(); xfer(8'h16, 8'ha6, 1, "sd_b0");
    xfer(8'h00, 8'h61, 1, "sd_status"); xfer(8'h00, 8'h01, 1, "sd_drive");
    xfer(8'h00, 8'h12, 1, "sd_lba3"); xfer(8'h00, 8'h34, 1, "sd_lba2");
    xfer(8'h00, 8'h56, 1, "sd_lba1"); xfer(8'h00, 8'h78, 1, "sd_lba0");
    xfer(8'h00, 8'h00, 1, "sd_tail"); frame_end();

    // 512-byte sector to the core
    frame_start(); xfer(8'h17, 8'ha6, 0, ""); wait_clk(2);
    check("sd_ack_rd", 64'(sd_ack), 64'h2);
    half = 2;
    for (int k = 0; k < 512; k++) begin
      d = 8'($urandom_range(0, 255));
      dout_q.push_back({1'b1, 9'(k), d});
      xfer(d, 0, 0, "");
    end
    half = 4;
    wait_clk(4);
    check("addr_sat", 64'(sd_buff_addr), 64'd511);
    frame_end();
    check("sd_ack_drop", 64'(sd_ack), 64'h0);
    check("addr_clr", 64'(sd_buff_addr), 64'h0);

    // sector from the core
    half = 8;
    frame_start(); xfer(8'h18, 8'ha6, 1, "wr_b0");
    for (int k = 0; k < 4; k++) xfer(8'h00, 8'(k) ^ 8'h3c, 1, "sd_din_miso");
    wait_clk(2);
    check("sd_ack_wr", 64'(sd_ack), 64'h2);
    frame_end();
    half = 4;

    // config bytes
    frame_start(); xfer(8'h19, 8'ha6, 0, ""); wait_clk(2);
    check("ack_conf", 64'(sd_ack_conf), 64'h1);
    dout_q.push_back({1'b0, 9'd0, 8'h5a}); xfer(8'h5a, 0, 0, "");
    dout_q.push_back({1'b0, 9'd0, 8'hc3}); xfer(8'hc3, 0, 0, "");
    frame_end();
    check("ack_conf_drop", 64'(sd_ack_conf), 64'h0);

    // mount, image size, rtc
    frame_start(); xfer(8'h1c, 8'ha6, 0, "");
    mnt_q.push_back(2'b10); xfer(8'h03, 0, 0, "");
    mnt_q.push_back(2'b01); xfer(8'h04, 0, 0, "");
    frame_end();
    v32 = $urandom();
    frame_start(); xfer(8'h1d, 8'ha6, 0, "");
    for (int b = 0; b < 4; b++) xfer(v32[b*8 +: 8], 0, 0, "");
    frame_end();
    check("img_size", 64'(img_size), 64'(v32));
    v64 = {$urandom(), $urandom()};
    frame_start(); xfer(8'h22, 8'ha6, 0, "");
    for (int b = 0; b < 8; b++) xfer(v64[b*8 +: 8], 0, 0, "");
    frame_end();
    check("rtc", rtc, v64);

    // reset in the middle of a sector transfer
    frame_start(); xfer(8'h17, 8'ha6, 0, "");
    dout_q.push_back({1'b1, 9'd0, 8'h99}); xfer(8'h99, 0, 0, "");
    dout_q.push_back({1'b1, 9'd1, 8'h98}); xfer(8'h98, 0, 0, "");
    wait_clk(2);
    reset = 1'b1; wait_clk(3); reset = 1'b0; wait_clk(2);
    check("midrst_sd_ack", 64'(sd_ack), 64'h0);
    check("midrst_addr", 64'(sd_buff_addr), 64'h0);
    check("midrst_rtc", rtc, 64'h0);
    xfer(8'h77, 0, 0, ""); xfer(8'h66, 0, 0, "");
    frame_end();
    frame_start(); xfer(8'h00, 8'ha6, 1, "core_type_after_reset"); frame_end();

    check("dout_q_left", 64'(dout_q.size()), 64'd0);
    check("kbd_q_left", 64'(kbd_q.size()), 64'd0);
    check("mnt_q_left", 64'(mnt_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
